fetch_sequencer: RTL and testbench

Program-counter and fetch controller for the 9-bit core. It drives the 8-bit address of the combinational instruction ROM and registers the returned word into an instruction register for decode. It applies jump and branch redirects from execute, squashing the wrong-path fetch. It detects the halt encoding and stops fetching, and flags a fault if the PC runs past the program length.

---
 rtl/baluga_isa_pkg.sv | 15 +
 rtl/fetch_pc_next.sv | 27 ++
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/baluga_isa_pkg.sv
// Shared ISA constants and fetch FSM state type for the 9-bit core.
package baluga_isa_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned ADDR_W  = 8;

  localparam logic [INSTR_W-1:0] HALT_WORD = 9'b0111_00_010;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection: jump beats branch, both only apply to a valid instr_out.
module fetch_pc_next (
  input  logic [7:0] i_pc,
  input  logic [7:0] i_instr_pc,
  input  logic       i_instr_valid,
  input  logic       i_jump_valid,
  input  logic [7:0] i_jump_target,
  input  logic       i_branch_taken,
  input  logic [7:0] i_branch_offset,
  output logic [7:0] o_pc_next,
  output logic       o_squash
);

  always_comb begin
    o_squash  = 1'b0;
    o_pc_next = i_pc + 8'd1;
    if (i_instr_valid && i_jump_valid) begin
      o_squash  = 1'b1;
      o_pc_next = i_jump_target;
    end else if (i_instr_valid && i_branch_taken) begin
      o_squash  = 1'b1;
      // Offset is relative to the instruction being executed, wraps mod 256.
      o_pc_next = i_instr_pc + i_branch_offset;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC and fetch controller: drives the ROM address, registers the fetched word,
// applies execute redirects, stops on the halt encoding and flags PC overrun.
module fetch_sequencer #(
  parameter logic [baluga_isa_pkg::ADDR_W-1:0]  START_ADDR = 8'd0,
  parameter logic [8:0]                         PROG_LEN   = 9'd256,
  parameter logic [baluga_isa_pkg::INSTR_W-1:0] HALT_WORD  = baluga_isa_pkg::HALT_WORD,
  parameter int unsigned                        CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic [7:0]       rom_address,
  input  logic [8:0]       rom_instruction,
  input  logic             jump_valid,
  input  logic [7:0]       jump_target,
  input  logic             branch_taken,
  input  logic [7:0]       branch_offset,
  output logic [8:0]       instr_out,
  output logic [7:0]       instr_pc,
  output logic             instr_valid,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] issued_count
);

  import baluga_isa_pkg::*;

  fetch_state_t       r_state, w_state_nxt;
  logic [7:0]         r_pc, w_pc_nxt;
  logic [8:0]         r_instr, w_instr_nxt;
  logic [7:0]         r_instr_pc, w_instr_pc_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_fault, w_fault_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0]         w_pc_seq;
  logic               w_squash;

  fetch_pc_next u_pc_next (
    .i_pc            (r_pc),
    .i_instr_pc      (r_instr_pc),
    .i_instr_valid   (r_valid),
    .i_jump_valid    (jump_valid),
    .i_jump_target   (jump_target),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .o_pc_next       (w_pc_seq),
    .o_squash        (w_squash)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= START_ADDR;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_fault    <= w_fault_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_fault_nxt    = r_fault;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = START_ADDR;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (w_squash) begin
            w_pc_nxt    = w_pc_seq;
            w_valid_nxt = 1'b0;
          end else if ({1'b0, r_pc} >= PROG_LEN) begin
            w_state_nxt = HALTED;
            w_fault_nxt = 1'b1;
            w_valid_nxt = 1'b0;
          end else begin
            w_instr_nxt    = rom_instruction;
            w_instr_pc_nxt = r_pc;
            w_valid_nxt    = 1'b1;
            if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
            // Halt word is still issued so decode sees it for one cycle.
            if (rom_instruction == HALT_WORD) w_state_nxt = HALTED;
            else                              w_pc_nxt    = w_pc_seq;
          end
        end
      end
      HALTED: begin
        if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = START_ADDR;
          w_fault_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b0;
        end else if (!stall) begin
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rom_address  = r_pc;
  assign instr_out    = r_instr;
  assign instr_pc     = r_instr_pc;
  assign instr_valid  = r_valid;
  assign halted       = (r_state == HALTED);
  assign fault        = r_fault;
  assign issued_count = r_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus random checks of fetch_sequencer against a cycle-level reference model.
module tb_fetch_sequencer;

  localparam logic [8:0] HALT = 9'b0111_00_010;
  localparam int         PLEN = 20;

  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic [7:0]  rom_address;
  logic [8:0]  rom_instruction;
  logic        jump_valid, branch_taken;
  logic [7:0]  jump_target, branch_offset;
  logic [8:0]  instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid, halted, fault;
  logic [15:0] issued_count;

  logic [8:0]  rom [256];
  assign rom_instruction = rom[rom_address];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .START_ADDR (8'd0),
    .PROG_LEN   (9'd20),
    .HALT_WORD  (HALT),
    .CNT_W      (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .stall           (stall),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .jump_valid      (jump_valid),
    .jump_target     (jump_target),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .halted          (halted),
    .fault           (fault),
    .issued_count    (issued_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: mode 0 = not started, 1 = fetching, 2 = stopped.
  int m_mode, m_pc, m_ir, m_ipc, m_iv, m_fault, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_pc = 0; m_ir = 0; m_ipc = 0; m_iv = 0; m_fault = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
    end else if (m_mode == 1) begin
      if (!stall) begin
        if (m_iv == 1 && jump_valid) begin
          m_pc = int'(jump_target); m_iv = 0;
        end else if (m_iv == 1 && branch_taken) begin
          m_pc = (m_ipc + int'(branch_offset)) % 256; m_iv = 0;
        end else if (m_pc >= PLEN) begin
          m_mode = 2; m_fault = 1; m_iv = 0;
        end else begin
          m_ir = int'(rom[m_pc]); m_ipc = m_pc; m_iv = 1;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          if (m_ir == int'(HALT)) m_mode = 2;
          else m_pc = (m_pc + 1) % 256;
        end
      end
    end else begin
      if (start) begin m_mode = 1; m_pc = 0; m_fault = 0; m_cnt = 0; m_iv = 0; end
      else if (!stall) m_iv = 0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("rom_address",  32'(rom_address),  32'(m_pc));
    check("instr_valid",  32'(instr_valid),  32'(m_iv));
    if (m_iv == 1) begin
      check("instr_out", 32'(instr_out), 32'(m_ir));
      check("instr_pc",  32'(instr_pc),  32'(m_ipc));
    end
    check("halted",       32'(halted),       32'(m_mode == 2));
    check("fault",        32'(fault),        32'(m_fault));
    check("issued_count", 32'(issued_count), 32'(m_cnt));
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) begin
      logic [8:0] w;
      w = 9'($urandom_range(0, 511));
      if (w == HALT) w = 9'd0;
      rom[i] = w;
    end
  endtask

  initial begin
    logic [7:0] saved_ipc;
    logic [8:0] saved_ir;
    int         guard;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    jump_valid = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_offset = '0;
    m_mode = 0; m_pc = 0; m_ir = 0; m_ipc = 0; m_iv = 0; m_fault = 0; m_cnt = 0;
    fill_rom();
    rom[4] = HALT;

    cycle(); cycle();
    check("reset instr_out", 32'(instr_out), 32'd0);
    check("reset instr_pc",  32'(instr_pc),  32'd0);
    reset = 1'b0;

    // Straight line to halt word at address 4.
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("seq instr_pc", 32'(instr_pc), 32'(i));
      check("seq valid",    32'(instr_valid), 32'd1);
    end
    check("halt halted",  32'(halted),    32'd1);
    check("halt word",    32'(instr_out), 32'(HALT));
    cycle();
    check("halt drop valid", 32'(instr_valid),  32'd0);
    check("halt count",      32'(issued_count), 32'd5);

    // Branch +2 from 7, then -2 from 9, then jump beating branch.
    rom[4] = 9'd0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    check("pre-branch pc", 32'(instr_pc), 32'd7);
    branch_taken = 1'b1; branch_offset = 8'd2; cycle();
    check("branch bubble", 32'(instr_valid), 32'd0);
    branch_taken = 1'b0; cycle();
    check("branch fwd", 32'(instr_pc), 32'd9);
    branch_taken = 1'b1; branch_offset = 8'hFE; cycle();
    branch_taken = 1'b0; cycle();
    check("branch back", 32'(instr_pc), 32'd7);
    jump_valid = 1'b1; jump_target = 8'd12; branch_taken = 1'b1; branch_offset = 8'd2; cycle();
    jump_valid = 1'b0; branch_taken = 1'b0; cycle();
    check("jump wins", 32'(instr_pc), 32'd12);
    cycle();

    // Stall with a pending jump held by execute.
    saved_ipc = instr_pc; saved_ir = instr_out;
    stall = 1'b1; jump_valid = 1'b1; jump_target = 8'd3;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall ipc",   32'(instr_pc),    32'(saved_ipc));
      check("stall ir",    32'(instr_out),   32'(saved_ir));
      check("stall valid", 32'(instr_valid), 32'd1);
      check("stall pc",    32'(rom_address), 32'd14);
    end
    stall = 1'b0; cycle();
    check("post-stall bubble", 32'(instr_valid), 32'd0);
    jump_valid = 1'b0; cycle();
    check("post-stall jump", 32'(instr_pc), 32'd3);
    guard = 0;
    while (!halted && guard < 40) begin cycle(); guard++; end
    check("overrun reached", 32'(halted), 32'd1);

    // Clean overrun run from 0 with PROG_LEN = 20.
    start = 1'b1; cycle(); start = 1'b0;
    check("restart fault clr", 32'(fault), 32'd0);
    for (int i = 0; i < 20; i++) cycle();
    check("last pc", 32'(instr_pc), 32'd19);
    cycle();
    check("ovr fault",  32'(fault),        32'd1);
    check("ovr halted", 32'(halted),       32'd1);
    check("ovr count",  32'(issued_count), 32'd20);
    start = 1'b1; cycle(); start = 1'b0;
    check("ovr restart fault", 32'(fault), 32'd0);
    cycle();
    check("ovr refetch", 32'(instr_pc), 32'd0);

    // Reset while stalled in RUN.
    cycle(); cycle();
    stall = 1'b1; reset = 1'b1; cycle();
    check("rst valid", 32'(instr_valid),  32'd0);
    check("rst count", 32'(issued_count), 32'd0);
    check("rst ipc",   32'(instr_pc),     32'd0);
    reset = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("rst stays idle", 32'(instr_valid), 32'd0);
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    check("rst resume", 32'(instr_pc), 32'd0);

    // Random traffic against the model.
    fill_rom();
    rom[$urandom_range(0, 19)] = HALT;
    rom[$urandom_range(0, 19)] = HALT;
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      start         = ($urandom_range(0, 15) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      jump_valid    = ($urandom_range(0, 7) == 0);
      jump_target   = 8'($urandom_range(0, 23));
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_offset = 8'($urandom_range(0, 255));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
